// File: rtl/otter_intc.sv
// rtl/otter_intc.sv - N-source interrupt controller: synchronise, latch, prioritise, present one intrpt line.
// Optional OTTER_INTC_SWI_EN adds a software trigger register at offset 0x14.
module otter_intc #(
    parameter int          NUM_SRC     = 8,
    parameter logic [31:0] BASE_ADDR   = 32'h1100_0100,
    parameter int          SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src,
    input  logic [31:0]        iobus_addr,
    input  logic [31:0]        iobus_out,
    input  logic               iobus_wr,
    input  logic               intrpt_taken,
    output logic               intrpt,
    output logic [4:0]         irq_id,
    output logic [31:0]        rd_data,
    output logic               rd_hit
);
    typedef enum logic {IDLE = 1'b0, SERVICE = 1'b1} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0][NUM_SRC-1:0] sync_q;
    logic [NUM_SRC-1:0] hist, lvl, rise;
    logic [NUM_SRC-1:0] enable, pending, mode;
    logic [NUM_SRC-1:0] active, w1c, claim_clr, sw_set, pend_nxt;
    logic [4:0]         win;
    logic               any_active, take, complete;
    logic [31:0]        off;
    logic               sel_en, sel_pend, sel_mode, sel_claim, sel_isr;
    logic               unused_bits;

    assign lvl        = sync_q[SYNC_STAGES-1];
    assign rise       = lvl & ~hist;
    assign active     = pending & enable;
    assign any_active = |active;

    // Register window decode; 0x14 only exists with the software trigger.
    assign off = iobus_addr - BASE_ADDR;
`ifdef OTTER_INTC_SWI_EN
    assign rd_hit = (off < 32'h18);
    logic sel_sw;
    assign sel_sw = rd_hit && (off[4:2] == 3'd5);
    assign sw_set = (iobus_wr && sel_sw) ? iobus_out[NUM_SRC-1:0] : '0;
`else
    assign rd_hit = (off < 32'h14);
    assign sw_set = '0;
`endif
    assign sel_en    = rd_hit && (off[4:2] == 3'd0);
    assign sel_pend  = rd_hit && (off[4:2] == 3'd1);
    assign sel_mode  = rd_hit && (off[4:2] == 3'd2);
    assign sel_claim = rd_hit && (off[4:2] == 3'd3);
    assign sel_isr   = rd_hit && (off[4:2] == 3'd4);

    assign unused_bits = ^{off, iobus_out};

    // Fixed priority: lowest index wins.
    always_comb begin
        win = 5'd0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) win = 5'(i);
        end
    end

    assign take     = (state == IDLE) && intrpt_taken && any_active;
    assign complete = (state == SERVICE) && iobus_wr && sel_claim && (iobus_out[4:0] == irq_id);
    assign w1c      = (iobus_wr && sel_pend) ? iobus_out[NUM_SRC-1:0] : '0;

    always_comb begin
        claim_clr = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            claim_clr[i] = take && mode[i] && (win == 5'(i));
        end
    end

    // Edge bits: clears applied before the new edge is ORed in, so a same-cycle edge wins.
    assign pend_nxt = (mode & ((pending & ~(w1c | claim_clr)) | rise))
                    | (~mode & lvl)
                    | sw_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q  <= '0;
            hist    <= '0;
            enable  <= '0;
            pending <= '0;
            mode    <= '0;
            irq_id  <= 5'd0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], src};
            hist    <= lvl;
            pending <= pend_nxt;
            if (iobus_wr && sel_en)   enable <= iobus_out[NUM_SRC-1:0];
            if (iobus_wr && sel_mode) mode   <= iobus_out[NUM_SRC-1:0];
            if (take)                 irq_id <= win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take)     state_nxt = SERVICE;
            SERVICE: if (complete) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        intrpt = (state == IDLE) && any_active;
    end

    always_comb begin
        rd_data = 32'h0;
        if (sel_en)    rd_data = 32'(enable);
        if (sel_pend)  rd_data = 32'(pending);
        if (sel_mode)  rd_data = 32'(mode);
        if (sel_claim) rd_data = any_active ? 32'(win) : 32'h8000_0000;
        if (sel_isr)   rd_data = {(state == SERVICE), 26'b0, irq_id};
    end
endmodule
